spi_burst_master: RTL and testbench

//   Byte-wide SPI master (mode 0, MSB first) that sits directly downstream of the I2C-to-SPI bridge FIFO pop logic.
//   It accepts one byte per tx_start pulse and shifts it out on MOSI while capturing MISO.
//   It holds CS low across back-to-back bytes, so an I2C write burst appears as one SPI frame.
//   CS releases only after an idle timeout with no new byte.

---
 rtl/spi_burst_master.sv | 122 ++++++++++++
 tb/tb_spi_burst_master.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_burst_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_burst_master
// Brief    : Mode-0 MSB-first byte SPI master; CS held low across back-to-back
//            bytes and released after an idle timeout.
// Revision : 1.0 - initial release
// ============================================================================
module spi_burst_master #(
  parameter int CLK_DIV     = 5,
  parameter int CS_SETUP    = 2,
  parameter int CS_IDLE_CYC = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_byte,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic [7:0] rx_byte,
  output logic       spi_sck,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic       spi_cs_n
);

  localparam int c_MAX_A   = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int c_MAX_CNT = (c_MAX_A > CS_IDLE_CYC) ? c_MAX_A : CS_IDLE_CYC;
  localparam int c_CNT_W   = $clog2(c_MAX_CNT + 1);

  localparam logic [1:0] c_ST_IDLE   = 2'd0;
  localparam logic [1:0] c_ST_SETUP  = 2'd1;
  localparam logic [1:0] c_ST_SHIFT  = 2'd2;
  localparam logic [1:0] c_ST_LINGER = 2'd3;

  logic [1:0]         r_state, w_next_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic [2:0]         r_bit;
  logic [7:0]         r_shift;
  logic [7:0]         r_rx_shift;

  logic w_start_ok, w_setup_end, w_half_end, w_rise, w_fall, w_last_fall, w_linger_exp;
  logic w_cs_n_nxt, w_busy_nxt, w_done_nxt, w_sck_nxt, w_mosi_nxt;

  assign w_start_ok   = tx_start && ((r_state == c_ST_IDLE) || (r_state == c_ST_LINGER));
  assign w_setup_end  = (r_state == c_ST_SETUP) && (r_cnt == c_CNT_W'(CS_SETUP - 1));
  assign w_half_end   = (r_state == c_ST_SHIFT) && (r_cnt == c_CNT_W'(CLK_DIV - 1));
  assign w_rise       = w_half_end && !spi_sck;
  assign w_fall       = w_half_end && spi_sck;
  assign w_last_fall  = w_fall && (r_bit == 3'd7);
  assign w_linger_exp = (r_state == c_ST_LINGER) && (r_cnt == c_CNT_W'(CS_IDLE_CYC));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_ST_IDLE;
    else        r_state <= w_next_state;
  end

  // A start in the LINGER expiry cycle takes priority over releasing CS.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_ST_IDLE:   if (tx_start) w_next_state = c_ST_SETUP;
      c_ST_SETUP:  if (w_setup_end) w_next_state = c_ST_SHIFT;
      c_ST_SHIFT:  if (w_last_fall) w_next_state = c_ST_LINGER;
      c_ST_LINGER: begin
        if (tx_start)          w_next_state = c_ST_SHIFT;
        else if (w_linger_exp) w_next_state = c_ST_IDLE;
      end
      default:     w_next_state = c_ST_IDLE;
    endcase
  end

  always_comb begin
    w_cs_n_nxt = (w_next_state == c_ST_IDLE);
    w_busy_nxt = (w_next_state == c_ST_SETUP) || (w_next_state == c_ST_SHIFT);
    w_done_nxt = w_last_fall;
    w_sck_nxt  = 1'b0;
    if (r_state == c_ST_SHIFT) w_sck_nxt = w_half_end ? ~spi_sck : spi_sck;
    w_mosi_nxt = spi_mosi;
    if (w_start_ok)                 w_mosi_nxt = tx_byte[7];
    else if (w_fall && !w_last_fall) w_mosi_nxt = r_shift[6];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_cs_n   <= 1'b1;
      spi_sck    <= 1'b0;
      spi_mosi   <= 1'b0;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
      rx_byte    <= 8'h00;
      r_cnt      <= '0;
      r_bit      <= 3'd0;
      r_shift    <= 8'h00;
      r_rx_shift <= 8'h00;
    end else begin
      spi_cs_n <= w_cs_n_nxt;
      spi_sck  <= w_sck_nxt;
      spi_mosi <= w_mosi_nxt;
      tx_busy  <= w_busy_nxt;
      tx_done  <= w_done_nxt;

      if (w_start_ok || w_setup_end || w_half_end || w_linger_exp || (r_state == c_ST_IDLE))
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 1'b1;

      if (w_start_ok) begin
        r_bit   <= 3'd0;
        r_shift <= tx_byte;
      end else if (w_fall) begin
        r_bit   <= r_bit + 3'd1;
        r_shift <= {r_shift[6:0], 1'b0};
      end

      if (w_rise) r_rx_shift[3'd7 - r_bit] <= spi_miso;
      if (w_last_fall) rx_byte <= r_rx_shift;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_burst_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_spi_burst_master
// Brief    : Scoreboard bench for spi_burst_master against a cycle-window model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_burst_master;

  localparam int CLK_DIV     = 5;
  localparam int CS_SETUP    = 2;
  localparam int CS_IDLE_CYC = 16;
  localparam int BYTE_CYC    = 16 * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_byte;
  logic       tx_start;
  logic       tx_busy, tx_done, spi_sck, spi_mosi, spi_miso, spi_cs_n;
  logic [7:0] rx_byte;

  spi_burst_master #(.CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_IDLE_CYC(CS_IDLE_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .tx_byte(tx_byte), .tx_start(tx_start),
    .tx_busy(tx_busy), .tx_done(tx_done), .rx_byte(rx_byte),
    .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_cs_n(spi_cs_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [7:0] tx; logic [7:0] rx; int done; } exp_t;
  exp_t sb[$];

  // Model: frame timing derived purely from accept cycles.
  int m_done = 0, m_acc = 0, cs_fall = 0, cs_rise = 0;
  bit have_frame = 0;

  int checks = 0, errors = 0;

  // Slave side: loopback or a fixed byte shifted out MSB first per rise.
  bit         loopback = 0;
  logic [7:0] slave_data = 8'h00;
  int         rises = 0;
  logic [2:0] sbit;
  logic [7:0] cap = 8'h00;
  logic       prev_sck = 1'b0;
  assign sbit     = rises[2:0];
  assign spi_miso = loopback ? spi_mosi : slave_data[3'd7 - sbit];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) tick();
  endtask

  task automatic model_reset();
    sb.delete();
    have_frame = 0;
    m_done = 0; m_acc = 0; cs_fall = 0; cs_rise = 0;
  endtask

  task automatic send(input logic [7:0] b, input logic [7:0] sdat, input bit lb);
    int c;
    c = cyc;
    if (c >= m_done) begin
      if (have_frame && c <= m_done + CS_IDLE_CYC) begin
        m_done = c + 1 + BYTE_CYC;
      end else begin
        cs_fall = c + 1;
        m_done  = c + 1 + CS_SETUP + BYTE_CYC;
      end
      cs_rise    = m_done + CS_IDLE_CYC + 1;
      m_acc      = c;
      have_frame = 1;
      loopback   = lb;
      slave_data = sdat;
      sb.push_back('{tx: b, rx: (lb ? b : sdat), done: m_done});
    end
    tx_byte  = b;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    tx_byte  = 8'($urandom);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst_n) begin
      rises    = 0;
      prev_sck = 1'b0;
      chk("rst_cs_n", spi_cs_n, 1);
      chk("rst_sck", spi_sck, 0);
      chk("rst_done", tx_done, 0);
      chk("rst_busy", tx_busy, 0);
      chk("rst_rx", rx_byte, 0);
    end else begin
      chk("cs_n", spi_cs_n, !(cyc >= cs_fall && cyc < cs_rise));
      chk("busy", tx_busy, (cyc > m_acc && cyc < m_done));
      if (spi_cs_n) chk("sck_idle", spi_sck, 0);
      if (spi_sck && !prev_sck) begin
        rises++;
        cap = {cap[6:0], spi_mosi};
      end
      prev_sck = spi_sck;
      if (tx_done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done @cyc %0d: got tx_done=1 expected 0", cyc);
        end else begin
          e = sb.pop_front();
          chk("rx_byte", rx_byte, e.rx);
          chk("mosi_bits", cap, e.tx);
          chk("sck_rises", rises, 8);
          chk("done_cyc", cyc, e.done);
        end
        rises = 0;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int t, gap;
    rst_n = 1'b0; tx_start = 1'b0; tx_byte = 8'h00;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    send(8'hA5, 8'h00, 1);                 // loopback
    wait_until(m_done + 2);
    send(8'hFF, 8'h3C, 0);                 // fixed MISO pattern
    wait_until(cs_rise + 2);

    send(8'h01, 8'h10, 0);                 // three-byte burst, one CS window
    wait_until(m_done + 3);
    send(8'h02, 8'h20, 0);
    wait_until(m_done + 3);
    send(8'h03, 8'h30, 0);
    wait_until(cs_rise + 1);

    send(8'hAA, 8'h5A, 0);                 // start during SHIFT is dropped
    wait_until(m_acc + 40);
    send(8'h55, 8'hFF, 0);
    wait_until(m_done + 1);

    t = m_done + CS_IDLE_CYC;              // start exactly in the expiry cycle
    wait_until(t);
    send(8'h96, 8'h69, 0);
    wait_until(cs_rise + 3);

    send(8'hC3, 8'h81, 0);                 // reset after 4th SCK rise
    wait_until(m_acc + 1 + CS_SETUP + 7 * CLK_DIV + 1);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_cs_n", spi_cs_n, 1);
    chk("async_sck", spi_sck, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    send(8'h3A, 8'hE7, 0);
    wait_until(cs_rise + 2);

    for (int i = 0; i < 40; i++) begin
      send(8'($urandom), 8'($urandom), bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        wait_until(m_acc + $urandom_range(1, BYTE_CYC));
        send(8'($urandom), 8'($urandom), 0);
      end
      gap = $urandom_range(0, CS_IDLE_CYC + 4);
      wait_until(m_done + gap);
    end

    wait_until(cs_rise + 3);
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
